// File: rtl/adder_chk_pkg.sv
// Shared types, constants and the golden-sum helper for the adder result checker.
package adder_chk_pkg;

  typedef enum logic [0:0] {CHK_RUN = 1'b0, CHK_HALT = 1'b1} chk_state_e;

  // Widest operand the golden model supports; callers zero-extend into it.
  localparam int unsigned CHK_MAX_WIDTH = 64;

  localparam int unsigned CHK_CNT_WIDTH = 32;
  localparam logic [CHK_CNT_WIDTH-1:0] CHK_CNT_SAT = '1;

  // Full-precision a + b + cin; the carry lands in bit CHK_MAX_WIDTH.
  function automatic logic [CHK_MAX_WIDTH:0] adder_expected(
    input logic [CHK_MAX_WIDTH-1:0] a,
    input logic [CHK_MAX_WIDTH-1:0] b,
    input logic                     cin
  );
    return {1'b0, a} + {1'b0, b} + (CHK_MAX_WIDTH+1)'(cin);
  endfunction

endpackage

// File: rtl/adder_chk_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module adder_chk_sat_counter #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] cnt
);

  localparam logic [CNT_WIDTH-1:0] SAT = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != SAT)) begin
      cnt <= cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/adder_result_checker.sv
// Two-stage checker grading an adder's {cout,sum} against a + b + cin.
// Optional halt-on-first-failure behaviour: define ADDER_CHECKER_HALT_ON_FAIL_EN.
module adder_result_checker
  import adder_chk_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned CNT_WIDTH = CHK_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 sample,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 cin,
  input  logic [WIDTH-1:0]     sum,
  input  logic                 cout,
  output logic                 result_valid,
  output logic                 result_pass,
  output logic [CNT_WIDTH-1:0] pass_cnt,
  output logic [CNT_WIDTH-1:0] fail_cnt,
  output logic                 err_sticky,
  output logic [WIDTH-1:0]     fail_a,
  output logic [WIDTH-1:0]     fail_b,
  output logic                 fail_cin,
  output logic [WIDTH:0]       fail_got,
  output logic [WIDTH:0]       fail_exp,
  output logic                 halted
);

  chk_state_e state_q, state_d;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic             s1_cin;
  logic [WIDTH:0]   s1_got;

  logic [WIDTH:0]   exp_c;
  logic             take_c, done_c, pass_c, fail_c;

  // Stage-2 compare; a clear on the same edge drops the comparison.
  always_comb begin
    take_c = sample && (state_q == CHK_RUN);
    exp_c  = (WIDTH+1)'(adder_expected(CHK_MAX_WIDTH'(s1_a), CHK_MAX_WIDTH'(s1_b), s1_cin));
    done_c = s1_valid && !clear;
    pass_c = (exp_c == s1_got);
    fail_c = done_c && !pass_c;
  end

  always_comb begin
    state_d = state_q;
`ifdef ADDER_CHECKER_HALT_ON_FAIL_EN
    if (clear) begin
      state_d = CHK_RUN;
    end else if (fail_c) begin
      state_d = CHK_HALT;
    end
`else
    state_d = CHK_RUN;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CHK_RUN;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef ADDER_CHECKER_HALT_ON_FAIL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted <= 1'b0;
    end else begin
      halted <= (state_d == CHK_HALT);
    end
  end
`else
  assign halted = 1'b0;
`endif

  // Stage 1: capture operands and observed adder outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_cin   <= 1'b0;
      s1_got   <= '0;
    end else if (clear) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_cin   <= 1'b0;
      s1_got   <= '0;
    end else begin
      s1_valid <= take_c;
      if (take_c) begin
        s1_a   <= a;
        s1_b   <= b;
        s1_cin <= cin;
        s1_got <= {cout, sum};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_valid <= 1'b0;
      result_pass  <= 1'b0;
    end else begin
      result_valid <= done_c;
      result_pass  <= done_c && pass_c;
    end
  end

  // First-failure snapshot; later failures leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_cin   <= 1'b0;
      fail_got   <= '0;
      fail_exp   <= '0;
    end else if (clear) begin
      err_sticky <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_cin   <= 1'b0;
      fail_got   <= '0;
      fail_exp   <= '0;
    end else if (fail_c && !err_sticky) begin
      err_sticky <= 1'b1;
      fail_a     <= s1_a;
      fail_b     <= s1_b;
      fail_cin   <= s1_cin;
      fail_got   <= s1_got;
      fail_exp   <= exp_c;
    end
  end

  adder_chk_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_pass_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (done_c && pass_c),
    .cnt   (pass_cnt)
  );

  adder_chk_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_fail_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (fail_c),
    .cnt   (fail_cnt)
  );

endmodule

// File: tb/tb_adder_result_checker.sv
// Randomized bench for adder_result_checker against a cycle-level arithmetic model.
module tb_adder_result_checker;

`ifdef ADDER_CHECKER_HALT_ON_FAIL_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk, rst_n, clear, sample, cin, cout;
  logic [15:0] a, b, sum;

  logic        rv, rp, err, fcin, hlt;
  logic [31:0] pcnt, fcnt;
  logic [15:0] fa, fb;
  logic [16:0] fgot, fexp;

  logic        rv4, rp4, err4, fcin4, hlt4;
  logic [3:0]  pcnt4, fcnt4;
  logic [15:0] fa4, fb4;
  logic [16:0] fgot4, fexp4;

  adder_result_checker #(.WIDTH(16), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .sample(sample),
    .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout),
    .result_valid(rv), .result_pass(rp), .pass_cnt(pcnt), .fail_cnt(fcnt),
    .err_sticky(err), .fail_a(fa), .fail_b(fb), .fail_cin(fcin),
    .fail_got(fgot), .fail_exp(fexp), .halted(hlt)
  );

  adder_result_checker #(.WIDTH(16), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .sample(sample),
    .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout),
    .result_valid(rv4), .result_pass(rp4), .pass_cnt(pcnt4), .fail_cnt(fcnt4),
    .err_sticky(err4), .fail_a(fa4), .fail_b(fb4), .fail_cin(fcin4),
    .fail_got(fgot4), .fail_exp(fexp4), .halted(hlt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference model: what the checker should report, in plain arithmetic.
  bit     m_pv, m_pcin, m_rv, m_rp, m_err, m_fcin, m_halt;
  longint m_pa, m_pb, m_pgot;
  longint m_pc, m_fc, m_pc4, m_fc4, m_fa, m_fb, m_fgot, m_fexp;

  task automatic model_zero();
    m_pv = 0; m_pcin = 0; m_rv = 0; m_rp = 0; m_err = 0; m_fcin = 0; m_halt = 0;
    m_pa = 0; m_pb = 0; m_pgot = 0;
    m_pc = 0; m_fc = 0; m_pc4 = 0; m_fc4 = 0;
    m_fa = 0; m_fb = 0; m_fgot = 0; m_fexp = 0;
  endtask

  task automatic model_edge(input bit smp, input longint ia, input longint ib,
                            input bit icin, input longint got, input bit iclr);
    longint e;
    bit     ok;
    bit     was_halted;
    if (iclr) begin
      model_zero();
      return;
    end
    was_halted = m_halt;
    m_rv = 0;
    m_rp = 0;
    if (m_pv) begin
      e  = m_pa + m_pb + longint'(m_pcin);
      ok = (e == m_pgot);
      m_rv = 1;
      m_rp = ok;
      if (ok) begin
        if (m_pc  < 64'hFFFF_FFFF) m_pc++;
        if (m_pc4 < 15) m_pc4++;
      end else begin
        if (m_fc  < 64'hFFFF_FFFF) m_fc++;
        if (m_fc4 < 15) m_fc4++;
        if (!m_err) begin
          m_err = 1; m_fa = m_pa; m_fb = m_pb; m_fcin = m_pcin;
          m_fgot = m_pgot; m_fexp = e;
          if (HALT_EN) m_halt = 1;
        end
      end
    end
    m_pv = smp && !was_halted;
    if (m_pv) begin
      m_pa = ia; m_pb = ib; m_pcin = icin; m_pgot = got;
    end
  endtask

  task automatic check_all();
    chk("result_valid", longint'(rv), longint'(m_rv));
    if (m_rv) chk("result_pass", longint'(rp), longint'(m_rp));
    chk("pass_cnt", longint'(pcnt), m_pc);
    chk("fail_cnt", longint'(fcnt), m_fc);
    chk("err_sticky", longint'(err), longint'(m_err));
    chk("fail_a", longint'(fa), m_fa);
    chk("fail_b", longint'(fb), m_fb);
    chk("fail_cin", longint'(fcin), longint'(m_fcin));
    chk("fail_got", longint'(fgot), m_fgot);
    chk("fail_exp", longint'(fexp), m_fexp);
    chk("halted", longint'(hlt), longint'(m_halt));
    chk("pass_cnt_w4", longint'(pcnt4), m_pc4);
    chk("fail_cnt_w4", longint'(fcnt4), m_fc4);
  endtask

  task automatic cyc(input bit smp, input logic [15:0] ia, input logic [15:0] ib,
                     input bit icin, input logic [16:0] got, input bit iclr);
    sample = smp; a = ia; b = ib; cin = icin; {cout, sum} = got; clear = iclr;
    @(posedge clk);
    model_edge(smp, longint'(ia), longint'(ib), icin, longint'(got), iclr);
    #1;
    check_all();
  endtask

  task automatic good(input logic [15:0] ia, input logic [15:0] ib, input bit icin);
    logic [16:0] s;
    s = 17'(longint'(ia) + longint'(ib) + longint'(icin));
    cyc(1'b1, ia, ib, icin, s, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 16'h0, 1'b0, 17'h0, 1'b0);
  endtask

  task automatic do_clear();
    cyc(1'b0, 16'h0, 16'h0, 1'b0, 17'h0, 1'b1);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic [16:0] rs, flip;
    bit          rc;
    rst_n = 1'b0; clear = 1'b0; sample = 1'b0; a = '0; b = '0; cin = 1'b0;
    sum = '0; cout = 1'b0;
    model_zero();
    #12;
    check_all();
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // Basic pass: result two edges after the sample.
    good(16'h1234, 16'h0001, 1'b1);
    chk("lat_edge1_rv", longint'(rv), 0);
    idle(1);
    chk("basic_rv", longint'(rv), 1);
    chk("basic_pass", longint'(rp), 1);
    idle(1);

    // Boundary: all-ones operands, then the same with cout forced low.
    good(16'hFFFF, 16'hFFFF, 1'b1);
    cyc(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 17'h0FFFF, 1'b0);
    idle(2);
    chk("bnd_fail_exp", longint'(fexp), 64'h1FFFF);
    chk("bnd_fail_got", longint'(fgot), 64'h0FFFF);
    do_clear();

    // Two consecutive failures: snapshot keeps the first one.
    cyc(1'b1, 16'd1, 16'd1, 1'b0, 17'h00003, 1'b0);
    cyc(1'b1, 16'd2, 16'd2, 1'b0, 17'h00005, 1'b0);
    idle(2);
    chk("two_fail_cnt", longint'(fcnt), 2);
    chk("two_fail_a", longint'(fa), 1);
    chk("two_fail_got", longint'(fgot), 3);
    chk("two_fail_exp", longint'(fexp), 2);
    do_clear();

    // 100 back-to-back random samples, some with corrupted results.
    for (int i = 0; i < 100; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      rs = 17'(longint'(ra) + longint'(rb) + longint'(rc));
      if ($urandom_range(3) == 0) begin
        flip = 17'($urandom_range(1, 17'h1FFFF));
        rs = rs ^ flip;
      end
      cyc(1'b1, ra, rb, rc, rs, 1'b0);
    end
    cyc(1'b1, 16'h0005, 16'h0006, 1'b0, 17'h0000B, 1'b1);
    chk("clr_pass_cnt", longint'(pcnt), 0);
    chk("clr_err", longint'(err), 0);
    idle(3);

    // Saturation of the 4-bit instance.
    for (int i = 0; i < 20; i++) good(16'(i * 7), 16'(i), 1'b0);
    idle(2);
    chk("sat_pass_cnt_w4", longint'(pcnt4), 15);

    // Asynchronous reset mid-stream.
    good(16'h00AA, 16'h0055, 1'b1);
    cyc(1'b1, 16'h0001, 16'h0001, 1'b0, 17'h00007, 1'b0);
    good(16'h0100, 16'h0200, 1'b0);
    #2;
    rst_n = 1'b0;
    model_zero();
    #1;
    check_all();
    @(posedge clk); #1;
    check_all();
    rst_n = 1'b1;
    idle(3);

    // Failure followed by passes; with the halt build the checker freezes.
    cyc(1'b1, 16'h0010, 16'h0020, 1'b0, 17'h00031, 1'b0);
    for (int i = 0; i < 5; i++) good(16'(i + 3), 16'h0100, 1'b1);
    idle(2);
    chk("halt_fail_cnt", longint'(fcnt), 1);
    do_clear();
    for (int i = 0; i < 3; i++) good(16'(i), 16'hFF00, 1'b1);
    idle(2);
    chk("resume_pass_cnt", longint'(pcnt), 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
